// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ packet sources.
// A grant is held for a whole packet and released on its last byte or on a gap timeout.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int GAP_TIMEOUT = 256
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic                      busy,
   output logic                      timeout_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOCK = 2'd1,
      LOAD = 2'd2,
      WAIT = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [IDX_W-1:0]    cur_r, cur_s;
   logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_s;
   logic [CNT_W-1:0]    gap_cnt_r, gap_cnt_s;
   logic                last_q_r, last_q_s;
   logic [NUM_REQ-1:0]  gnt_s;
   logic [DATA_W-1:0]   tx_data_s;
   logic                timeout_s;

   logic                pick_found_s;
   logic [IDX_W-1:0]    pick_s;
   logic [IDX_W-1:0]    cand_s;
   logic                sel_valid_s;
   logic                sel_last_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic [NUM_REQ-1:0]  cur_oh_s;

   // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      pick_found_s = 1'b0;
      pick_s       = {IDX_W{1'b0}};
      cand_s       = {IDX_W{1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
         if (!pick_found_s && req_valid[cand_s]) begin
            pick_found_s = 1'b1;
            pick_s       = cand_s;
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Mux out the current owner's valid/last/data and its one-hot code
   always_comb begin
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = {DATA_W{1'b0}};
      cur_oh_s    = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cur_r == IDX_W'(i)) begin
            sel_valid_s = req_valid[i];
            sel_last_s  = req_last[i];
            sel_data_s  = req_data[i*DATA_W +: DATA_W];
            cur_oh_s[i] = 1'b1;
         end else begin
            cur_oh_s[i] = 1'b0;
         end
      end
   end

   // Next-state logic, register updates and the combinational ready strobe
   always_comb begin
      state_s   = state_r;
      cur_s     = cur_r;
      rr_ptr_s  = rr_ptr_r;
      gap_cnt_s = gap_cnt_r;
      last_q_s  = last_q_r;
      gnt_s     = gnt;
      tx_data_s = tx_data;
      timeout_s = 1'b0;
      req_ready = {NUM_REQ{1'b0}};
      case (state_r)
         IDLE: begin
            gap_cnt_s = {CNT_W{1'b0}};
            if (pick_found_s) begin
               cur_s   = pick_s;
               gnt_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
               state_s = LOCK;
            end else begin
               state_s = IDLE;
            end
         end
         LOCK: begin
            if (sel_valid_s) begin
               req_ready = cur_oh_s;
               tx_data_s = sel_data_s;
               last_q_s  = sel_last_s;
               gap_cnt_s = {CNT_W{1'b0}};
               state_s   = LOAD;
            end else if (gap_cnt_r == CNT_W'(GAP_TIMEOUT - 1)) begin
               // Owner went silent mid-packet: give the transmitter to the next requester
               timeout_s = 1'b1;
               rr_ptr_s  = cur_r;
               gnt_s     = {NUM_REQ{1'b0}};
               gap_cnt_s = {CNT_W{1'b0}};
               state_s   = IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + CNT_W'(1);
            end
         end
         LOAD: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (tx_done) begin
               if (last_q_r) begin
                  rr_ptr_s = cur_r;
                  gnt_s    = {NUM_REQ{1'b0}};
                  state_s  = IDLE;
               end else begin
                  state_s  = LOCK;
               end
            end else begin
               state_s = WAIT;
            end
         end
         default: begin
            state_s = IDLE;
            gnt_s   = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // State and output registers; tx_start/busy are decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cur_r       <= {IDX_W{1'b0}};
         rr_ptr_r    <= IDX_W'(NUM_REQ - 1);
         gap_cnt_r   <= {CNT_W{1'b0}};
         last_q_r    <= 1'b0;
         gnt         <= {NUM_REQ{1'b0}};
         tx_data     <= {DATA_W{1'b0}};
         tx_start    <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_r     <= state_s;
         cur_r       <= cur_s;
         rr_ptr_r    <= rr_ptr_s;
         gap_cnt_r   <= gap_cnt_s;
         last_q_r    <= last_q_s;
         gnt         <= gnt_s;
         tx_data     <= tx_data_s;
         tx_start    <= (state_s == LOAD);
         busy        <= (state_s != IDLE);
         timeout_err <= timeout_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a simple transmitter model
// and per-scenario tasks comparing logged tx_start/grant events with hand-computed values.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   gnt;
   logic           tx_start;
   logic [W-1:0]   tx_data;
   logic           tx_done;
   logic           busy;
   logic           timeout_err;

   logic           tx_done_a = 1'b0;
   logic           tx_done_m = 1'b0;
   logic           tx_auto = 1'b1;
   int             tx_cnt = 0;
   assign tx_done = tx_done_a | tx_done_m;

   int checks = 0;
   int errors = 0;

   logic [8:0]     src_q [N][$];
   logic [N-1:0]   ready_seen = '0;
   logic [11:0]    tx_log [$];
   int             tx_cyc [$];
   logic [N-1:0]   gnt_log [$];
   logic [N-1:0]   gnt_prev = '0;
   int             cyc_n = 0;
   int             to_cnt = 0;
   int             to_cyc = 0;
   logic [N-1:0]   to_gnt = '0;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .gnt(gnt), .tx_start(tx_start),
      .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Monitor, transmitter model and requester model, all stepped on the falling edge
   always @(negedge clk) begin
      cyc_n++;
      if (tx_start) begin
         tx_log.push_back({gnt, tx_data});
         tx_cyc.push_back(cyc_n);
      end
      if (gnt != '0 && gnt != gnt_prev) gnt_log.push_back(gnt);
      gnt_prev = gnt;
      if (timeout_err) begin
         to_cnt++;
         to_cyc = cyc_n;
         to_gnt = gnt;
      end
      tx_done_a = 1'b0;
      if (tx_cnt != 0) begin
         tx_cnt--;
         if (tx_cnt == 0) tx_done_a = 1'b1;
      end
      if (tx_auto && tx_start) tx_cnt = 2;
      for (int i = 0; i < N; i++) begin
         if (ready_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[i*W +: W] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
      #1 ready_seen = req_ready;
   end

   task automatic clear_logs();
      tx_log.delete();
      tx_cyc.delete();
      gnt_log.delete();
      to_cnt = 0;
   endtask

   task automatic wait_log(input int n, input string nm);
      int k = 0;
      while (tx_log.size() < n && k < 300) begin
         @(posedge clk);
         k++;
      end
      #3;
      checks++;
      if (tx_log.size() < n) begin
         errors++;
         $display("FAIL %s_timeout got %0d tx_start want %0d", nm, tx_log.size(), n);
      end
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy !== 1'b0 && k < 300) begin
         @(posedge clk);
         #3;
         k++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_timeout got busy=%b want 0", nm, busy);
      end
   endtask

   task automatic check_log(input int idx, input logic [11:0] exp, input string nm);
      checks++;
      if (tx_log[idx] !== exp) begin
         errors++;
         $display("FAIL %s_byte%0d got %h want %h", nm, idx, tx_log[idx], exp);
      end
   endtask

   task automatic check_gnt_log(input int idx, input logic [N-1:0] exp, input string nm);
      checks++;
      if (gnt_log[idx] !== exp) begin
         errors++;
         $display("FAIL %s_grant%0d got %b want %b", nm, idx, gnt_log[idx], exp);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         src_q[i].push_back(9'h110 + 9'(i));
         src_q[i].push_back(9'h120 + 9'(i));
      end
      repeat (3) @(posedge clk);
      #3;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b want 0000", req_ready); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start got %b want 0", tx_start); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", timeout_err); end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready got %b want 0000", req_ready); end
      @(posedge clk);
      #3;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got %b want 0001", gnt); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL first_ready got %b want 0001", req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL first_busy got %b want 1", busy); end
   endtask

   task automatic test_round_robin();
      wait_log(8, "rr");
      wait_idle("rr");
      for (int k = 0; k < 8; k++) begin
         check_log(k, {4'b0001 << (k % 4), 8'h10 + 8'((k / 4) * 16) + 8'(k % 4)}, "rr");
         check_gnt_log(k, 4'b0001 << (k % 4), "rr");
      end
   endtask

   task automatic test_packet_lock();
      clear_logs();
      src_q[0].push_back(9'h0A1);
      src_q[0].push_back(9'h0A2);
      src_q[0].push_back(9'h1A3);
      src_q[2].push_back(9'h1B1);
      wait_log(4, "lock");
      wait_idle("lock");
      check_log(0, 12'h1A1, "lock");
      check_log(1, 12'h1A2, "lock");
      check_log(2, 12'h1A3, "lock");
      check_log(3, 12'h4B1, "lock");
      checks++; if (tx_log.size() != 4) begin errors++; $display("FAIL lock_count got %0d want 4", tx_log.size()); end
      checks++; if (gnt_log.size() != 2) begin errors++; $display("FAIL lock_grants got %0d want 2", gnt_log.size()); end
      check_gnt_log(0, 4'b0001, "lock");
      check_gnt_log(1, 4'b0100, "lock");
   endtask

   task automatic test_gap_timeout();
      clear_logs();
      src_q[1].push_back(9'h051);
      src_q[2].push_back(9'h162);
      wait_log(2, "gap");
      wait_idle("gap");
      check_log(0, 12'h251, "gap");
      check_log(1, 12'h462, "gap");
      checks++; if (to_cnt != 1) begin errors++; $display("FAIL gap_pulses got %0d want 1", to_cnt); end
      checks++; if (to_gnt !== 4'b0000) begin errors++; $display("FAIL gap_gnt got %b want 0000", to_gnt); end
      if (tx_cyc.size() > 0) begin
         checks++;
         if (to_cyc - tx_cyc[0] != 11) begin
            errors++;
            $display("FAIL gap_latency got %0d want 11", to_cyc - tx_cyc[0]);
         end
      end
      check_gnt_log(0, 4'b0010, "gap");
      check_gnt_log(1, 4'b0100, "gap");
   endtask

   task automatic test_spurious_done();
      int k = 0;
      clear_logs();
      tx_auto   = 1'b0;
      tx_done_m = 1'b1;
      src_q[0].push_back(9'h071);
      src_q[0].push_back(9'h172);
      while (tx_start !== 1'b1 && k < 30) begin
         @(posedge clk);
         #3;
         k++;
      end
      checks++; if (tx_data !== 8'h71) begin errors++; $display("FAIL spur_first got %h want 71", tx_data); end
      @(posedge clk);
      #3;
      tx_done_m = 1'b0;
      checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL spur_wait got busy=%b ready=%b want 1/0000", busy, req_ready);
      end
      repeat (3) @(posedge clk);
      #3;
      checks++; if (tx_log.size() != 1 || tx_data !== 8'h71) begin
         errors++; $display("FAIL spur_hold got n=%0d data=%h want 1/71", tx_log.size(), tx_data);
      end
      tx_done_m = 1'b1;
      @(posedge clk);
      #3;
      tx_done_m = 1'b0;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL spur_next_ready got %b want 0001", req_ready); end
      tx_auto = 1'b1;
      wait_log(2, "spur");
      wait_idle("spur");
      check_log(0, 12'h171, "spur");
      check_log(1, 12'h172, "spur");
      checks++; if (gnt_log.size() != 1) begin errors++; $display("FAIL spur_grants got %0d want 1", gnt_log.size()); end
   endtask

   task automatic test_reset_mid_packet();
      clear_logs();
      src_q[3].push_back(9'h083);
      src_q[3].push_back(9'h184);
      src_q[0].push_back(9'h190);
      wait_log(1, "rstmid");
      checks++; if (gnt !== 4'b1000 || busy !== 1'b1 || tx_start !== 1'b0) begin
         errors++; $display("FAIL rstmid_wait got gnt=%b busy=%b start=%b want 1000/1/0", gnt, busy, tx_start);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL rstmid_async got gnt=%b busy=%b data=%h ready=%b want 0000/0/00/0000",
                            gnt, busy, tx_data, req_ready);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      wait_log(3, "rstmid");
      wait_idle("rstmid");
      check_log(0, 12'h883, "rstmid");
      check_log(1, 12'h190, "rstmid");
      check_log(2, 12'h884, "rstmid");
      checks++; if (tx_log.size() != 3) begin errors++; $display("FAIL rstmid_count got %0d want 3", tx_log.size()); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_packet_lock();
      test_gap_timeout();
      test_spurious_done();
      test_reset_mid_packet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "global timeout");
   end

endmodule
